// File: rtl/row_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a ROWS x COLS register bank.
// Includes a sequential full-array clear that takes priority over all requests.
module row_bank_arbiter #(
  parameter int ROWS = 10,
  parameter int COLS = 20,
  localparam int RW = $clog2(ROWS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_req,
  input  logic [1:0]               i_we,
  input  logic [1:0][RW-1:0]       i_row,
  input  logic [1:0][COLS-1:0]     i_wdata,
  input  logic                     i_clr,
  output logic [1:0]               o_gnt,
  output logic [1:0]               o_rvalid,
  output logic [COLS-1:0]          o_rdata,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [COLS-1:0]          o_top
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [RW-1:0]             cnt_q, cnt_d;
  logic                      last_q, last_d;
  logic [ROWS-1:0][COLS-1:0] mem_q, mem_d;
  logic [1:0]                rvalid_q, rvalid_d;
  logic [COLS-1:0]           rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [1:0]                gnt_s;
  logic                      sel_s;
  logic [RW-1:0]             row_s;
  logic                      in_range_s;

  // Grant logic: clear requests and the clear sequence both suppress grants.
  always_comb begin
    gnt_s = 2'b00;
    if (state_q == IDLE && !i_clr) begin
      if (i_req == 2'b11) begin
        gnt_s = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_s = i_req;
      end
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign sel_s      = gnt_s[1];
  assign row_s      = i_row[sel_s];
  assign in_range_s = ({1'b0, row_s} < (RW+1)'(ROWS));

  // Next-state for FSM, storage, pointer and registered read/error outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    mem_d    = mem_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d = CLEAR;
          cnt_d   = RW'(ROWS - 1);
        end else if (gnt_s != 2'b00) begin
          last_d = sel_s;
          err_d  = !in_range_s;
          if (i_we[sel_s]) begin
            if (in_range_s) begin
              mem_d[row_s] = i_wdata[sel_s];
            end else begin
              mem_d = mem_q;
            end
          end else begin
            rvalid_d = gnt_s;
            rdata_d  = in_range_s ? mem_q[row_s] : {COLS{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        // Clears from the top row down so o_top drops on the first cycle.
        mem_d[cnt_q] = {COLS{1'b0}};
        if (cnt_q == {RW{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {RW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= {RW{1'b0}};
      last_q   <= 1'b1;
      mem_q    <= '0;
      rvalid_q <= 2'b00;
      rdata_q  <= {COLS{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_gnt    = gnt_s;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q == CLEAR);
  assign o_top    = mem_q[ROWS-1];

endmodule

// File: tb/tb_row_bank_arbiter.sv
// Randomised and directed bench for row_bank_arbiter against a behavioural model
// that tracks storage as an int array and the clear as a remaining-rows count.
module tb_row_bank_arbiter;
  localparam int ROWS = 10;
  localparam int COLS = 20;
  localparam int RW   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req, we;
  logic [1:0][RW-1:0]   row;
  logic [1:0][COLS-1:0] wdata;
  logic                 clr;
  logic [1:0]           gnt, rvalid;
  logic [COLS-1:0]      rdata, top;
  logic                 err, busy;

  always #5 clk = ~clk;

  row_bank_arbiter #(.ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_row(row),
    .i_wdata(wdata), .i_clr(clr), .o_gnt(gnt), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_err(err), .o_busy(busy), .o_top(top)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference state
  int         m_mem[ROWS];
  int         m_clr_left;
  int         m_last;
  logic [1:0] m_rvalid;
  int         m_rdata;
  logic       m_err;

  function automatic void model_reset();
    for (int i = 0; i < ROWS; i++) m_mem[i] = 0;
    m_clr_left = 0;
    m_last     = 1;
    m_rvalid   = 2'b00;
    m_rdata    = 0;
    m_err      = 1'b0;
  endfunction

  // One clock cycle: drive, compare all outputs with the model, advance the model.
  task automatic step(input logic [1:0] rq, input logic [1:0] w, input int r0, input int r1,
                      input int d0, input int d1, input logic c);
    logic [1:0] g;
    int k, r, d;
    @(negedge clk);
    req = rq; we = w; clr = c;
    row[0] = RW'(r0); row[1] = RW'(r1);
    wdata[0] = COLS'(d0); wdata[1] = COLS'(d1);
    #1;
    if (m_clr_left > 0 || c) g = 2'b00;
    else if (rq == 2'b11) g = (m_last == 1) ? 2'b01 : 2'b10;
    else g = rq;
    check_eq("gnt", 32'(gnt), 32'(g));
    check_eq("busy", 32'(busy), 32'(m_clr_left > 0));
    check_eq("top", 32'(top), 32'(m_mem[ROWS-1]));
    check_eq("rvalid", 32'(rvalid), 32'(m_rvalid));
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
    check_eq("err", 32'(err), 32'(m_err));
    m_rvalid = 2'b00;
    m_err    = 1'b0;
    if (m_clr_left > 0) begin
      m_mem[m_clr_left-1] = 0;
      m_clr_left--;
    end else if (c) begin
      m_clr_left = ROWS;
    end else if (g != 2'b00) begin
      k = g[1] ? 1 : 0;
      r = (k == 1) ? r1 : r0;
      d = ((k == 1) ? d1 : d0) & ((1 << COLS) - 1);
      m_last = k;
      m_err  = (r >= ROWS);
      if (w[k]) begin
        if (r < ROWS) m_mem[r] = d;
      end else begin
        m_rvalid = g;
        m_rdata  = (r < ROWS) ? m_mem[r] : 0;
      end
    end
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; row = '0; wdata = '0; clr = 1'b0;
    model_reset();
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_top", 32'(top), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Round-robin on persistent conflict
    step(2'b11, 2'b00, 0, 0, 0, 0, 1'b0); check_eq("rr_0", 32'(gnt), 32'h1);
    step(2'b11, 2'b00, 0, 0, 0, 0, 1'b0); check_eq("rr_1", 32'(gnt), 32'h2);
    step(2'b11, 2'b00, 0, 0, 0, 0, 1'b0); check_eq("rr_2", 32'(gnt), 32'h1);

    // Write then read back
    step(2'b01, 2'b01, 3, 0, 32'h12345, 0, 1'b0);
    step(2'b01, 2'b00, 3, 0, 0, 0, 1'b0);
    idle();
    check_eq("wr_rvalid", 32'(rvalid), 32'h1);
    check_eq("wr_rdata", 32'(rdata), 32'h12345);

    // Out-of-range read
    step(2'b10, 2'b00, 0, 12, 0, 0, 1'b0); check_eq("oor_gnt", 32'(gnt), 32'h2);
    idle();
    check_eq("oor_rvalid", 32'(rvalid), 32'h2);
    check_eq("oor_rdata", 32'(rdata), 32'h0);
    check_eq("oor_err", 32'(err), 32'h1);
    idle();
    check_eq("oor_err_end", 32'(err), 32'h0);

    // Clear sequence with requests held and i_clr kept high inside CLEAR
    step(2'b01, 2'b01, 9, 0, 32'hFFFFF, 0, 1'b0);
    idle();
    check_eq("fill_top", 32'(top), 32'hFFFFF);
    step(2'b01, 2'b00, 0, 0, 0, 0, 1'b1); check_eq("clr_nognt", 32'(gnt), 32'h0);
    for (int i = 0; i < ROWS; i++) begin
      step(2'b01, 2'b00, 0, 0, 0, 0, (i < ROWS - 1));
      check_eq("clr_busy", 32'(busy), 32'h1);
      if (i == 1) check_eq("clr_top", 32'(top), 32'h0);
    end
    step(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
    check_eq("post_clr_busy", 32'(busy), 32'h0);
    check_eq("post_clr_gnt", 32'(gnt), 32'h1);
    for (int r = 0; r < ROWS; r++) step(2'b01, 2'b00, r, 0, 0, 0, 1'b0);

    // Reset in the middle of a clear
    for (int r = 0; r < ROWS; r++) step(2'b10, 2'b10, 0, r, 0, int'($urandom), 1'b0);
    step(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_top", 32'(top), 32'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      step(2'b01, 2'b00, r, 0, 0, 0, 1'b0);
      check_eq("mid_rst_gnt", 32'(gnt), 32'h1);
    end
    idle();
    check_eq("mid_rst_rd9", 32'(rdata), 32'h0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      step(2'($urandom), 2'($urandom), $urandom_range(0, 11), $urandom_range(0, 11),
           int'($urandom), int'($urandom), ($urandom_range(0, 24) == 0));
    end
    for (int n = 0; n < ROWS + 2; n++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
